// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXE/MEM/WB sequencing with PC/IR strobes.
// Optional retired-instruction counter compiled in with `define MCTRL_PERF_EN.
module multicycle_ctrl #(
    parameter int STATE_W = 4,
    parameter int PERF_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               overflow,
    output logic               pc_write,
    output logic               ir_write,
    output logic [1:0]         alu_ctl,
    output logic               ext_op,
    output logic               alu_src,
    output logic [1:0]         reg_dst,
    output logic [1:0]         reg_src,
    output logic               npc_sel,
    output logic               j_ctl,
    output logic               jr_ctl,
    output logic               mem_write,
    output logic               reg_write,
    output logic               illegal,
    output logic [STATE_W-1:0] state,
    output logic [PERF_W-1:0]  retired
);

    // state | meaning
    // 0 FETCH  | load IR, PC <= PC+4
    // 1 DECODE | classify instruction, flag illegal
    // 2 EXE    | ALU operation
    // 3 MEM_RD | data memory read
    // 4 MEM_WR | data memory write
    // 5 WB_ALU | write ALU result (or $30 on addi overflow)
    // 6 WB_MEM | write loaded data
    // 7 BRANCH | beq compare and conditional PC load
    // 8 JUMP   | j/jal/jr PC load, jal link write
    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_EXE, S_MEM_RD, S_MEM_WR,
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP
    } state_e;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_SLT, C_JR, C_ORI, C_ADDI,
        C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } iclass_e;

    state_e  state_q, state_d;
    logic    ovf_q;
    iclass_e cls;

    always_comb begin
        cls = C_ILL;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: cls = C_ADDU;
                    6'b100011: cls = C_SUBU;
                    6'b101010: cls = C_SLT;
                    6'b001000: cls = C_JR;
                    default:   cls = C_ILL;
                endcase
            end
            6'b001101: cls = C_ORI;
            6'b001000: cls = C_ADDI;
            6'b100011: cls = C_LW;
            6'b101011: cls = C_SW;
            6'b000100: cls = C_BEQ;
            6'b000010: cls = C_J;
            6'b000011: cls = C_JAL;
            default:   cls = C_ILL;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    C_ADDU, C_SUBU, C_SLT, C_ORI,
                    C_ADDI, C_LW, C_SW:       state_d = S_EXE;
                    C_JR, C_J, C_JAL:         state_d = S_JUMP;
                    C_BEQ:                    state_d = S_BRANCH;
                    default:                  state_d = S_FETCH;
                endcase
            end
            S_EXE: begin
                case (cls)
                    C_LW:    state_d = S_MEM_RD;
                    C_SW:    state_d = S_MEM_WR;
                    default: state_d = S_WB_ALU;
                endcase
            end
            S_MEM_RD: state_d = S_WB_MEM;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Overflow only matters for addi; clear it for everything else so a stale flag never leaks.
            if (state_q == S_EXE) begin
                ovf_q <= (cls == C_ADDI) && overflow;
            end
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        alu_ctl   = 2'b00;
        ext_op    = 1'b0;
        alu_src   = 1'b0;
        reg_dst   = 2'b00;
        reg_src   = 2'b00;
        npc_sel   = 1'b0;
        j_ctl     = 1'b0;
        jr_ctl    = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
                S_DECODE: illegal = (cls == C_ILL);
                S_EXE: begin
                    case (cls)
                        C_ADDU: alu_ctl = 2'b00;
                        C_SUBU: alu_ctl = 2'b01;
                        C_SLT:  alu_ctl = 2'b11;
                        C_ORI: begin
                            alu_src = 1'b1;
                            alu_ctl = 2'b10;
                        end
                        C_ADDI, C_LW, C_SW: begin
                            alu_src = 1'b1;
                            ext_op  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM_WR: mem_write = 1'b1;
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    if (cls == C_ADDU || cls == C_SUBU || cls == C_SLT) begin
                        reg_dst = 2'b01;
                    end else if (cls == C_ADDI && ovf_q) begin
                        // Overflowing addi leaves rt intact and sets $30 to 1 instead.
                        reg_dst = 2'b10;
                        reg_src = 2'b10;
                    end
                end
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    reg_src   = 2'b01;
                end
                S_BRANCH: begin
                    alu_ctl  = 2'b01;
                    ext_op   = 1'b1;
                    npc_sel  = 1'b1;
                    pc_write = zero;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    if (cls == C_JR) begin
                        jr_ctl = 1'b1;
                    end else begin
                        j_ctl = 1'b1;
                    end
                    if (cls == C_JAL) begin
                        reg_write = 1'b1;
                        reg_dst   = 2'b11;
                        reg_src   = 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = rst ? '0 : state_q;

`ifdef MCTRL_PERF_EN
    logic [PERF_W-1:0] retired_q;
    logic              retire;

    // Every completing state returns to FETCH, so being in one means a retirement this edge.
    assign retire = (state_q == S_MEM_WR) || (state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
                    (state_q == S_BRANCH) || (state_q == S_JUMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + PERF_W'(1);
        end
    end

    assign retired = rst ? '0 : retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; per-cycle tables of state and control outputs.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        overflow = 1'b0;
    logic        pc_write, ir_write, ext_op, alu_src, npc_sel, j_ctl, jr_ctl;
    logic        mem_write, reg_write, illegal;
    logic [1:0]  alu_ctl, reg_dst, reg_src;
    logic [3:0]  state;
    logic [31:0] retired;
    logic [15:0] outs;

    int checks = 0;
    int fails = 0;
    int exp_ret = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pc_write(pc_write), .ir_write(ir_write),
        .alu_ctl(alu_ctl), .ext_op(ext_op), .alu_src(alu_src), .reg_dst(reg_dst),
        .reg_src(reg_src), .npc_sel(npc_sel), .j_ctl(j_ctl), .jr_ctl(jr_ctl),
        .mem_write(mem_write), .reg_write(reg_write), .illegal(illegal),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // pw iw alu ext src dst rsrc npc j jr mw rw ill
    assign outs = {pc_write, ir_write, alu_ctl, ext_op, alu_src, reg_dst, reg_src,
                   npc_sel, j_ctl, jr_ctl, mem_write, reg_write, illegal};

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_E = 4'd2, S_MR = 4'd3, S_MW = 4'd4,
                           S_WA = 4'd5, S_WM = 4'd6, S_BR = 4'd7, S_J = 4'd8;

    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_ADDI = 6'b001000,
                           OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                           OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_SLT = 6'b101010,
                           F_JR = 6'b001000, F_BAD = 6'b000000;

    localparam logic [15:0]
        O_FETCH  = 16'b1_1_00_0_0_00_00_0_0_0_0_0_0,
        O_NONE   = 16'b0_0_00_0_0_00_00_0_0_0_0_0_0,
        O_EXE_SU = 16'b0_0_01_0_0_00_00_0_0_0_0_0_0,
        O_EXE_SL = 16'b0_0_11_0_0_00_00_0_0_0_0_0_0,
        O_EXE_OR = 16'b0_0_10_0_1_00_00_0_0_0_0_0_0,
        O_EXE_IM = 16'b0_0_00_1_1_00_00_0_0_0_0_0_0,
        O_WB_R   = 16'b0_0_00_0_0_01_00_0_0_0_0_1_0,
        O_WB_I   = 16'b0_0_00_0_0_00_00_0_0_0_0_1_0,
        O_WB_OVF = 16'b0_0_00_0_0_10_10_0_0_0_0_1_0,
        O_WB_MEM = 16'b0_0_00_0_0_00_01_0_0_0_0_1_0,
        O_MEM_WR = 16'b0_0_00_0_0_00_00_0_0_0_1_0_0,
        O_BR_T   = 16'b1_0_01_1_0_00_00_1_0_0_0_0_0,
        O_BR_N   = 16'b0_0_01_1_0_00_00_1_0_0_0_0_0,
        O_JMP    = 16'b1_0_00_0_0_00_00_0_1_0_0_0_0,
        O_JAL    = 16'b1_0_00_0_0_11_11_0_1_0_0_1_0,
        O_JR     = 16'b1_0_00_0_0_00_00_0_0_1_0_0_0,
        O_ILL    = 16'b0_0_00_0_0_00_00_0_0_0_0_0_1;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ov;
        logic [3:0]  st;
        logic [15:0] ex;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_r;
        rst = 1'b1;
        opcode = OP_JAL;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({state, outs} !== {S_F, O_NONE}) begin
                fails++;
                $display("FAIL reset_outs[%0d]: state=%0d outs=%b, expected state=0 outs=%b", k, state, outs, O_NONE);
            end
            checks++;
            if (retired !== 32'd0) begin
                fails++;
                $display("FAIL reset_retired[%0d]: got %0d expected 0", k, retired);
            end
        end
        rst = 1'b0;
        opcode = OP_R;
        #1;
        checks++;
        if ({state, outs} !== {S_F, O_FETCH}) begin
            fails++;
            $display("FAIL reset_release: state=%0d outs=%b, expected state=0 outs=%b", state, outs, O_FETCH);
        end
        exp_r = 32'd0;
        checks++;
        if (retired !== exp_r) begin
            fails++;
            $display("FAIL reset_release_retired: got %0d expected %0d", retired, exp_r);
        end
    endtask

    task automatic test_rtype();
        vec_t v [12];
        logic [31:0] exp_r;
        v = '{
            {OP_R, F_ADDU, 1'b0, 1'b0, S_F,  O_FETCH},
            {OP_R, F_ADDU, 1'b0, 1'b0, S_D,  O_NONE},
            {OP_R, F_ADDU, 1'b0, 1'b0, S_E,  O_NONE},
            {OP_R, F_ADDU, 1'b0, 1'b0, S_WA, O_WB_R},
            {OP_R, F_SUBU, 1'b0, 1'b1, S_F,  O_FETCH},
            {OP_R, F_SUBU, 1'b0, 1'b1, S_D,  O_NONE},
            {OP_R, F_SUBU, 1'b0, 1'b1, S_E,  O_EXE_SU},
            {OP_R, F_SUBU, 1'b0, 1'b1, S_WA, O_WB_R},
            {OP_R, F_SLT,  1'b1, 1'b0, S_F,  O_FETCH},
            {OP_R, F_SLT,  1'b1, 1'b0, S_D,  O_NONE},
            {OP_R, F_SLT,  1'b1, 1'b0, S_E,  O_EXE_SL},
            {OP_R, F_SLT,  1'b1, 1'b0, S_WA, O_WB_R}
        };
        for (int k = 0; k < 12; k++) begin
            opcode = v[k].op; funct = v[k].fn; zero = v[k].z; overflow = v[k].ov;
            #1;
            checks++;
            if ({state, outs} !== {v[k].st, v[k].ex}) begin
                fails++;
                $display("FAIL rtype[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", k, state, outs, v[k].st, v[k].ex);
            end
            tick();
        end
        exp_ret += 3;
        checks++;
        if (state !== S_F) begin
            fails++;
            $display("FAIL rtype_end_state: got %0d expected 0", state);
        end
`ifdef MCTRL_PERF_EN
        exp_r = 32'(exp_ret);
`else
        exp_r = 32'd0;
`endif
        checks++;
        if (retired !== exp_r) begin
            fails++;
            $display("FAIL rtype_retired: got %0d expected %0d", retired, exp_r);
        end
    endtask

    task automatic test_lw_sw();
        vec_t v [9];
        logic [31:0] exp_r;
        v = '{
            {OP_LW, F_BAD, 1'b0, 1'b0, S_F,  O_FETCH},
            {OP_LW, F_BAD, 1'b0, 1'b0, S_D,  O_NONE},
            {OP_LW, F_BAD, 1'b0, 1'b0, S_E,  O_EXE_IM},
            {OP_LW, F_BAD, 1'b0, 1'b0, S_MR, O_NONE},
            {OP_LW, F_BAD, 1'b0, 1'b0, S_WM, O_WB_MEM},
            {OP_SW, F_BAD, 1'b1, 1'b1, S_F,  O_FETCH},
            {OP_SW, F_BAD, 1'b1, 1'b1, S_D,  O_NONE},
            {OP_SW, F_BAD, 1'b1, 1'b1, S_E,  O_EXE_IM},
            {OP_SW, F_BAD, 1'b1, 1'b1, S_MW, O_MEM_WR}
        };
        for (int k = 0; k < 9; k++) begin
            opcode = v[k].op; funct = v[k].fn; zero = v[k].z; overflow = v[k].ov;
            #1;
            checks++;
            if ({state, outs} !== {v[k].st, v[k].ex}) begin
                fails++;
                $display("FAIL lw_sw[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", k, state, outs, v[k].st, v[k].ex);
            end
            tick();
        end
        exp_ret += 2;
        checks++;
        if (state !== S_F) begin
            fails++;
            $display("FAIL lw_sw_end_state: got %0d expected 0", state);
        end
`ifdef MCTRL_PERF_EN
        exp_r = 32'(exp_ret);
`else
        exp_r = 32'd0;
`endif
        checks++;
        if (retired !== exp_r) begin
            fails++;
            $display("FAIL lw_sw_retired: got %0d expected %0d", retired, exp_r);
        end
    endtask

    task automatic test_beq();
        vec_t v [6];
        logic [31:0] exp_r;
        v = '{
            {OP_BEQ, F_BAD, 1'b1, 1'b0, S_F,  O_FETCH},
            {OP_BEQ, F_BAD, 1'b1, 1'b0, S_D,  O_NONE},
            {OP_BEQ, F_BAD, 1'b1, 1'b0, S_BR, O_BR_T},
            {OP_BEQ, F_BAD, 1'b0, 1'b0, S_F,  O_FETCH},
            {OP_BEQ, F_BAD, 1'b0, 1'b0, S_D,  O_NONE},
            {OP_BEQ, F_BAD, 1'b0, 1'b0, S_BR, O_BR_N}
        };
        for (int k = 0; k < 6; k++) begin
            opcode = v[k].op; funct = v[k].fn; zero = v[k].z; overflow = v[k].ov;
            #1;
            checks++;
            if ({state, outs} !== {v[k].st, v[k].ex}) begin
                fails++;
                $display("FAIL beq[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", k, state, outs, v[k].st, v[k].ex);
            end
            tick();
        end
        exp_ret += 2;
        checks++;
        if (state !== S_F) begin
            fails++;
            $display("FAIL beq_end_state: got %0d expected 0", state);
        end
`ifdef MCTRL_PERF_EN
        exp_r = 32'(exp_ret);
`else
        exp_r = 32'd0;
`endif
        checks++;
        if (retired !== exp_r) begin
            fails++;
            $display("FAIL beq_retired: got %0d expected %0d", retired, exp_r);
        end
    endtask

    task automatic test_addi_ovf();
        vec_t v [12];
        logic [31:0] exp_r;
        v = '{
            {OP_ADDI, F_BAD, 1'b0, 1'b1, S_F,  O_FETCH},
            {OP_ADDI, F_BAD, 1'b0, 1'b1, S_D,  O_NONE},
            {OP_ADDI, F_BAD, 1'b0, 1'b1, S_E,  O_EXE_IM},
            {OP_ADDI, F_BAD, 1'b0, 1'b1, S_WA, O_WB_OVF},
            {OP_ADDI, F_BAD, 1'b0, 1'b0, S_F,  O_FETCH},
            {OP_ADDI, F_BAD, 1'b0, 1'b0, S_D,  O_NONE},
            {OP_ADDI, F_BAD, 1'b0, 1'b0, S_E,  O_EXE_IM},
            {OP_ADDI, F_BAD, 1'b0, 1'b0, S_WA, O_WB_I},
            {OP_ORI,  F_BAD, 1'b0, 1'b1, S_F,  O_FETCH},
            {OP_ORI,  F_BAD, 1'b0, 1'b1, S_D,  O_NONE},
            {OP_ORI,  F_BAD, 1'b0, 1'b1, S_E,  O_EXE_OR},
            {OP_ORI,  F_BAD, 1'b0, 1'b1, S_WA, O_WB_I}
        };
        for (int k = 0; k < 12; k++) begin
            opcode = v[k].op; funct = v[k].fn; zero = v[k].z; overflow = v[k].ov;
            #1;
            checks++;
            if ({state, outs} !== {v[k].st, v[k].ex}) begin
                fails++;
                $display("FAIL addi_ovf[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", k, state, outs, v[k].st, v[k].ex);
            end
            tick();
        end
        exp_ret += 3;
        checks++;
        if (state !== S_F) begin
            fails++;
            $display("FAIL addi_end_state: got %0d expected 0", state);
        end
`ifdef MCTRL_PERF_EN
        exp_r = 32'(exp_ret);
`else
        exp_r = 32'd0;
`endif
        checks++;
        if (retired !== exp_r) begin
            fails++;
            $display("FAIL addi_retired: got %0d expected %0d", retired, exp_r);
        end
    endtask

    task automatic test_jump_illegal();
        vec_t v [13];
        logic [31:0] exp_r;
        v = '{
            {OP_JAL, F_BAD, 1'b0, 1'b0, S_F, O_FETCH},
            {OP_JAL, F_BAD, 1'b0, 1'b0, S_D, O_NONE},
            {OP_JAL, F_BAD, 1'b0, 1'b0, S_J, O_JAL},
            {OP_BAD, F_BAD, 1'b0, 1'b0, S_F, O_FETCH},
            {OP_BAD, F_BAD, 1'b0, 1'b0, S_D, O_ILL},
            {OP_J,   F_BAD, 1'b0, 1'b0, S_F, O_FETCH},
            {OP_J,   F_BAD, 1'b0, 1'b0, S_D, O_NONE},
            {OP_J,   F_BAD, 1'b0, 1'b0, S_J, O_JMP},
            {OP_R,   F_JR,  1'b0, 1'b0, S_F, O_FETCH},
            {OP_R,   F_JR,  1'b0, 1'b0, S_D, O_NONE},
            {OP_R,   F_JR,  1'b0, 1'b0, S_J, O_JR},
            {OP_R,   F_BAD, 1'b0, 1'b0, S_F, O_FETCH},
            {OP_R,   F_BAD, 1'b0, 1'b0, S_D, O_ILL}
        };
        for (int k = 0; k < 13; k++) begin
            opcode = v[k].op; funct = v[k].fn; zero = v[k].z; overflow = v[k].ov;
            #1;
            checks++;
            if ({state, outs} !== {v[k].st, v[k].ex}) begin
                fails++;
                $display("FAIL jump_illegal[%0d]: state=%0d outs=%b, expected state=%0d outs=%b", k, state, outs, v[k].st, v[k].ex);
            end
            tick();
        end
        exp_ret += 3;
        checks++;
        if ({state, illegal} !== {S_F, 1'b0}) begin
            fails++;
            $display("FAIL illegal_one_cycle: state=%0d illegal=%b expected state=0 illegal=0", state, illegal);
        end
`ifdef MCTRL_PERF_EN
        exp_r = 32'(exp_ret);
`else
        exp_r = 32'd0;
`endif
        checks++;
        if (retired !== exp_r) begin
            fails++;
            $display("FAIL jump_retired: got %0d expected %0d", retired, exp_r);
        end
    endtask

    task automatic test_reset_abort();
        opcode = OP_LW; funct = F_BAD; zero = 1'b0; overflow = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== S_E) begin
            fails++;
            $display("FAIL abort_pre_state: got %0d expected 2", state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({state, outs} !== {S_F, O_NONE}) begin
            fails++;
            $display("FAIL abort_in_reset: state=%0d outs=%b expected state=0 outs=%b", state, outs, O_NONE);
        end
        tick();
        checks++;
        if ({state, outs, retired} !== {S_F, O_NONE, 32'd0}) begin
            fails++;
            $display("FAIL abort_held: state=%0d outs=%b retired=%0d expected 0/%b/0", state, outs, retired, O_NONE);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({state, outs} !== {S_F, O_FETCH}) begin
            fails++;
            $display("FAIL abort_release: state=%0d outs=%b expected state=0 outs=%b", state, outs, O_FETCH);
        end
        tick();
        checks++;
        if ({state, outs} !== {S_D, O_NONE}) begin
            fails++;
            $display("FAIL abort_restart: state=%0d outs=%b expected state=1 outs=%b", state, outs, O_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_sw();
        test_beq();
        test_addi_ovf();
        test_jump_illegal();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
